// File: rtl/mul_nibble_seq_ctrl.sv
// Sequential OPW x OPW unsigned multiplier built from one external 4x4 array multiplier.
// Optional macro ZERO_SKIP_EN: a zero operand bypasses RUN and goes straight to DONE with product 0.
module mul_nibble_seq_ctrl #(
  parameter int OPW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    in_a,
  input  logic [OPW-1:0]    in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OPW-1:0]  out_p,
  output logic              busy,
  output logic [3:0]        m_a,
  output logic [3:0]        m_b,
  input  logic [7:0]        m_p
);

  // state  | meaning
  // IDLE   | waiting for an operand pair, in_ready high
  // RUN    | one nibble pair per cycle through the 4x4 multiplier, accumulating
  // DONE   | product presented on out_p until the consumer takes it

  localparam int C  = OPW / 4;
  localparam int N  = C * C;
  localparam int PW = 2 * OPW;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [CW-1:0]   ic, jc;
  logic [OPW-1:0]  opa, opb;
  logic [PW-1:0]   acc;

  logic [PW-1:0]   pp, acc_sum;
  logic [CW-1:0]   ic_nxt, jc_nxt;
  logic            last_step, col_wrap, skip;

  function automatic logic [3:0] nib(input logic [OPW-1:0] v, input logic [CW-1:0] idx);
    logic [OPW-1:0] s;
    s = v >> (4 * int'(idx));
    return s[3:0];
  endfunction

  // ic/jc track i = k % C and j = k / C without a divider.
  always_comb begin
    pp        = {{(PW-8){1'b0}}, m_p} << (4 * (int'(ic) + int'(jc)));
    acc_sum   = acc + pp;
    last_step = (k == KW'(N - 1));
    col_wrap  = (ic == CW'(C - 1));
    ic_nxt    = col_wrap ? '0 : ic + 1'b1;
    jc_nxt    = col_wrap ? jc + 1'b1 : jc;
  end

`ifdef ZERO_SKIP_EN
  assign skip = (in_a == '0) || (in_b == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      ic        <= '0;
      jc        <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      m_a       <= '0;
      m_b       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            opa      <= in_a;
            opb      <= in_b;
            acc      <= '0;
            k        <= '0;
            ic       <= '0;
            jc       <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (skip) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_p     <= '0;
            end else begin
              state <= S_RUN;
              m_a   <= in_a[3:0];
              m_b   <= in_b[3:0];
            end
          end
        end
        S_RUN: begin
          acc <= acc_sum;
          if (last_step) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_p     <= acc_sum;
            m_a       <= '0;
            m_b       <= '0;
          end else begin
            // Nibbles are registered one cycle ahead so m_p is valid for the current k.
            k   <= k + 1'b1;
            ic  <= ic_nxt;
            jc  <= jc_nxt;
            m_a <= nib(opa, ic_nxt);
            m_b <= nib(opb, jc_nxt);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_nibble_seq_ctrl.sv
// Self-checking bench for mul_nibble_seq_ctrl: OPW=8 and OPW=16 instances, each with a behavioural 4x4 multiplier.
module tb_mul_nibble_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_a8, in_b8, m_p8;
  logic [15:0] out_p8;
  logic [3:0]  m_a8, m_b8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] in_a16, in_b16;
  logic [7:0]  m_p16;
  logic [31:0] out_p16;
  logic [3:0]  m_a16, m_b16;

  assign m_p8  = {4'b0, m_a8} * {4'b0, m_b8};
  assign m_p16 = {4'b0, m_a16} * {4'b0, m_b16};

  mul_nibble_seq_ctrl #(.OPW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_p(out_p8), .busy(busy8), .m_a(m_a8), .m_b(m_b8), .m_p(m_p8));

  mul_nibble_seq_ctrl #(.OPW(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_p(out_p16), .busy(busy16), .m_a(m_a16), .m_b(m_b16), .m_p(m_p16));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          hold;
    logic [15:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One full transaction on the 8-bit instance; expected timing comes from the nibble-count rule.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold, input logic [15:0] exp);
    int lat;
    int exp_lat;
    logic [3:0] ea, eb;
    exp_lat = 4;
`ifdef ZERO_SKIP_EN
    if (a == 0 || b == 0) exp_lat = 0;
`endif
    @(negedge clk);
    chk("idle_ready", in_ready8, 1);
    chk("idle_nib", {m_a8, m_b8}, 0);
    in_valid8 = 1; in_a8 = a; in_b8 = b; out_ready8 = 0;
    @(negedge clk);
    in_valid8 = 0; in_a8 = 8'($urandom); in_b8 = 8'($urandom);
    chk("acc_busy", busy8, 1);
    chk("acc_ready", in_ready8, 0);
    lat = 0;
    while (!out_valid8 && lat < 64) begin
      if (lat < exp_lat) begin
        ea = 4'(a >> (4 * (lat % 2)));
        eb = 4'(b >> (4 * (lat / 2)));
        chk("run_nib", {m_a8, m_b8}, {ea, eb});
      end
      chk("run_ready", in_ready8, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", out_valid8, 1);
      chk("hold_p", out_p8, exp);
      chk("hold_nib", {m_a8, m_b8}, 0);
      @(negedge clk);
    end
    chk("out_p", out_p8, exp);
    out_ready8 = 1;
    @(negedge clk);
    out_ready8 = 0;
    chk("hs_valid", out_valid8, 0);
    chk("hs_ready", in_ready8, 1);
    chk("hs_busy", busy8, 0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0]  ra, rb;
    logic [7:0]  ba[3], bb[3];
    logic [15:0] bp[3];
    int nin, nout, cyc, last_out, lat;
    logic fire_in, fire_out;

    vecs[0] = '{8'hFF, 8'hFF, 0, 16'hFE01};
    vecs[1] = '{8'hA7, 8'h3C, 3, 16'h2724};
    vecs[2] = '{8'h00, 8'h5A, 1, 16'h0000};
    vecs[3] = '{8'h01, 8'h01, 0, 16'h0001};
    vecs[4] = '{8'h0F, 8'hF0, 2, 16'h0E10};
    vecs[5] = '{8'h80, 8'h02, 0, 16'h0100};

    rst_n = 0;
    in_valid8 = 0; in_a8 = 0; in_b8 = 0; out_ready8 = 0;
    in_valid16 = 0; in_a16 = 0; in_b16 = 0; out_ready16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid8, 0);
    chk("rst_p", out_p8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_nib", {m_a8, m_b8}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", in_ready8, 1);
    chk("rst_ready16", in_ready16, 1);

    for (int v = 0; v < 6; v++) run8(vecs[v].a, vecs[v].b, vecs[v].hold, vecs[v].p);

    for (int r = 0; r < 20; r++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run8(ra, rb, int'($urandom_range(0, 3)), 16'(ra) * 16'(rb));
    end

    // in_valid held high with three pairs; producer advances only on an accept.
    for (int i = 0; i < 3; i++) begin
      ba[i] = 8'($urandom_range(1, 255));
      bb[i] = 8'($urandom_range(1, 255));
      bp[i] = 16'(ba[i]) * 16'(bb[i]);
    end
    @(negedge clk);
    nin = 0; nout = 0; cyc = 0; last_out = 0;
    in_valid8 = 1; in_a8 = ba[0]; in_b8 = bb[0]; out_ready8 = 1;
    while (nout < 3 && cyc < 60) begin
      fire_in  = in_valid8 && in_ready8;
      fire_out = out_valid8 && out_ready8;
      if (fire_in) chk("b2b_idle", busy8, 0);
      if (fire_out) begin
        chk("b2b_p", out_p8, bp[nout]);
        if (nout > 0) chk("b2b_gap", cyc - last_out, 6);
        last_out = cyc;
        nout++;
      end
      @(negedge clk);
      cyc++;
      if (fire_in) begin
        nin++;
        if (nin < 3) begin in_a8 = ba[nin]; in_b8 = bb[nin]; end
        else in_valid8 = 0;
      end
    end
    chk("b2b_count", nout, 3);
    in_valid8 = 0; out_ready8 = 0;
    @(negedge clk);

    // Reset in the second RUN cycle discards the product.
    in_valid8 = 1; in_a8 = 8'h12; in_b8 = 8'h34;
    @(negedge clk);
    in_valid8 = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mrst_valid", out_valid8, 0);
    chk("mrst_p", out_p8, 0);
    chk("mrst_busy", busy8, 0);
    chk("mrst_nib", {m_a8, m_b8}, 0);
    @(negedge clk);
    rst_n = 1;
    run8(8'h02, 8'h03, 0, 16'h0006);

    // 16-bit instance: 16 RUN cycles.
    @(negedge clk);
    in_valid16 = 1; in_a16 = 16'hFFFF; in_b16 = 16'hFFFF; out_ready16 = 0;
    @(negedge clk);
    in_valid16 = 0;
    lat = 0;
    while (!out_valid16 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("w16_latency", lat, 16);
    chk("w16_p", out_p16, 32'hFFFE0001);
    out_ready16 = 1;
    @(negedge clk);
    out_ready16 = 0;
    chk("w16_hs", out_valid16, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
